// File: rtl/kyber_ntt_sequencer_if.sv
// Handshake and address bus between the NTT sequencer and its controller/datapath.
// Signal names use the sequencer's own view: i_ = into the sequencer, o_ = out of it.
interface kyber_ntt_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int ZETA_W = 7
);
   logic              i_start;
   logic              i_inverse;
   logic              i_hold;
   logic              o_busy;
   logic              o_done;
   logic              o_rd_en;
   logic [ADDR_W-1:0] o_rd_addr_a;
   logic [ADDR_W-1:0] o_rd_addr_b;
   logic [ZETA_W-1:0] o_zeta_idx;
   logic              o_bf_inv;
   logic [2:0]        o_layer;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr_a;
   logic [ADDR_W-1:0] o_wr_addr_b;

   modport master (
      output i_start, i_inverse, i_hold,
      input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_zeta_idx,
             o_bf_inv, o_layer, o_wr_en, o_wr_addr_a, o_wr_addr_b
   );

   modport slave (
      input  i_start, i_inverse, i_hold,
      output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_zeta_idx,
             o_bf_inv, o_layer, o_wr_en, o_wr_addr_a, o_wr_addr_b
   );
endinterface

// File: rtl/kyber_ntt_sequencer.sv
// Address/twiddle sequencer for one forward or inverse 256-point Kyber NTT pass:
// 7 layers x 128 butterflies, PIPE_LAT-matched write-back and inter-layer drain gaps.
module kyber_ntt_sequencer #(
   parameter int PIPE_LAT = 6,   // legal range 1..32
   parameter int ADDR_W   = 8,
   parameter int ZETA_W   = 7
) (
   input logic                   clk,
   input logic                   reset,
   kyber_ntt_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

   localparam logic [5:0] DRAIN_LAST = 6'(PIPE_LAT - 1);

   state_t            r_state, w_next;
   logic [6:0]        r_cnt;
   logic [2:0]        r_layer;
   logic              r_inv;
   logic [5:0]        r_drain;
   logic [ADDR_W-1:0] r_last_a, r_last_b;
   logic [ZETA_W-1:0] r_last_z;

   logic              w_rd_en, w_busy, w_done, w_drain_end;
   logic [2:0]        w_shift;
   logic [3:0]        w_shift_grp;
   logic [6:0]        w_group;
   logic [ADDR_W-1:0] w_len, w_offset, w_addr_a, w_addr_b;
   logic [7:0]        w_zeta_f, w_zeta_i;
   logic [ZETA_W-1:0] w_zeta;

   logic [PIPE_LAT-1:0] r_dly_en;
   logic [ADDR_W-1:0]   r_dly_a [PIPE_LAT];
   logic [ADDR_W-1:0]   r_dly_b [PIPE_LAT];

   assign w_drain_end = (r_drain == DRAIN_LAST);

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      w_next  = r_state;
      w_rd_en = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE:   if (bus.i_start) w_next = S_ISSUE;
         S_ISSUE: begin
            w_busy  = 1'b1;
            w_rd_en = ~bus.i_hold;
            if (w_rd_en && r_cnt == 7'd127) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (w_drain_end) w_next = (r_layer == 3'd6) ? S_FINISH : S_ISSUE;
         end
         S_FINISH: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_layer <= '0;
         r_inv   <= 1'b0;
         r_drain <= '0;
      end else if (r_state == S_IDLE && bus.i_start) begin
         r_cnt   <= '0;
         r_layer <= '0;
         r_inv   <= bus.i_inverse;
         r_drain <= '0;
      end else if (w_rd_en) begin
         r_cnt <= r_cnt + 7'd1;
      end else if (r_state == S_DRAIN) begin
         if (w_drain_end) begin
            r_drain <= '0;
            if (r_layer != 3'd6) r_layer <= r_layer + 3'd1;
         end else begin
            r_drain <= r_drain + 6'd1;
         end
      end
   end

   // Butterfly index splits into group (high bits) and offset (low log2(len) bits).
   always_comb begin
      w_shift     = r_inv ? (r_layer + 3'd1) : (3'd7 - r_layer);
      w_shift_grp = {1'b0, w_shift} + 4'd1;
      w_len       = ADDR_W'(1) << w_shift;
      w_group     = r_cnt >> w_shift;
      w_offset    = {1'b0, r_cnt} & (w_len - ADDR_W'(1));
      w_addr_a    = ({1'b0, w_group} << w_shift_grp) | w_offset;
      w_addr_b    = w_addr_a + w_len;
      w_zeta_f    = (8'd1 << r_layer) + {1'b0, w_group};
      w_zeta_i    = (8'd128 >> r_layer) - 8'd1 - {1'b0, w_group};
      w_zeta      = r_inv ? ZETA_W'(w_zeta_i) : ZETA_W'(w_zeta_f);
   end

   // Address outputs hold the last issued butterfly while no read is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_a <= '0;
         r_last_b <= '0;
         r_last_z <= '0;
      end else if (w_rd_en) begin
         r_last_a <= w_addr_a;
         r_last_b <= w_addr_b;
         r_last_z <= w_zeta;
      end
   end

   // NOTE: the delay line is reset so in-flight writes are dropped on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dly_en <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            r_dly_a[i] <= '0;
            r_dly_b[i] <= '0;
         end
      end else begin
         r_dly_en[0] <= w_rd_en;
         r_dly_a[0]  <= w_addr_a;
         r_dly_b[0]  <= w_addr_b;
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_dly_en[i] <= r_dly_en[i-1];
            r_dly_a[i]  <= r_dly_a[i-1];
            r_dly_b[i]  <= r_dly_b[i-1];
         end
      end
   end

   assign bus.o_busy      = w_busy;
   assign bus.o_done      = w_done;
   assign bus.o_rd_en     = w_rd_en;
   assign bus.o_rd_addr_a = w_rd_en ? w_addr_a : r_last_a;
   assign bus.o_rd_addr_b = w_rd_en ? w_addr_b : r_last_b;
   assign bus.o_zeta_idx  = w_rd_en ? w_zeta : r_last_z;
   assign bus.o_bf_inv    = r_inv;
   assign bus.o_layer     = r_layer;
   assign bus.o_wr_en     = r_dly_en[PIPE_LAT-1];
   assign bus.o_wr_addr_a = r_dly_a[PIPE_LAT-1];
   assign bus.o_wr_addr_b = r_dly_b[PIPE_LAT-1];

endmodule

// File: tb/tb_kyber_ntt_sequencer.sv
// Scoreboard bench for kyber_ntt_sequencer: PIPE_LAT=6 and PIPE_LAT=1 instances share stimulus;
// a monitor checks the selected instance against a reference issue queue and directed vectors.
module tb_kyber_ntt_sequencer;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [6:0] z;
      logic [2:0] layer;
      logic       inv;
   } rd_t;

   typedef struct {
      int         cyc;
      logic [7:0] a;
      logic [7:0] b;
   } wr_t;

   typedef struct {
      logic inv;
      logic wr;
      int   rel;
      int   a;
      int   b;
      int   z;
   } dir_t;

   logic clk = 1'b0;
   logic reset;
   logic start, inverse, hold;
   logic sel;

   kyber_ntt_sequencer_if #(.ADDR_W(8), .ZETA_W(7)) b0 ();
   kyber_ntt_sequencer_if #(.ADDR_W(8), .ZETA_W(7)) b1 ();

   kyber_ntt_sequencer #(.PIPE_LAT(6), .ADDR_W(8), .ZETA_W(7)) dut6 (
      .clk(clk), .reset(reset), .bus(b0.slave));
   kyber_ntt_sequencer #(.PIPE_LAT(1), .ADDR_W(8), .ZETA_W(7)) dut1 (
      .clk(clk), .reset(reset), .bus(b1.slave));

   assign b0.i_start = start;   assign b1.i_start = start;
   assign b0.i_inverse = inverse; assign b1.i_inverse = inverse;
   assign b0.i_hold = hold;     assign b1.i_hold = hold;

   logic       m_busy, m_done, m_rd_en, m_bf_inv, m_wr_en;
   logic [7:0] m_rd_a, m_rd_b, m_wr_a, m_wr_b;
   logic [6:0] m_z;
   logic [2:0] m_layer;
   logic [46:0] m_all;

   assign m_busy   = sel ? b1.o_busy      : b0.o_busy;
   assign m_done   = sel ? b1.o_done      : b0.o_done;
   assign m_rd_en  = sel ? b1.o_rd_en     : b0.o_rd_en;
   assign m_rd_a   = sel ? b1.o_rd_addr_a : b0.o_rd_addr_a;
   assign m_rd_b   = sel ? b1.o_rd_addr_b : b0.o_rd_addr_b;
   assign m_z      = sel ? b1.o_zeta_idx  : b0.o_zeta_idx;
   assign m_bf_inv = sel ? b1.o_bf_inv    : b0.o_bf_inv;
   assign m_layer  = sel ? b1.o_layer     : b0.o_layer;
   assign m_wr_en  = sel ? b1.o_wr_en     : b0.o_wr_en;
   assign m_wr_a   = sel ? b1.o_wr_addr_a : b0.o_wr_addr_a;
   assign m_wr_b   = sel ? b1.o_wr_addr_b : b0.o_wr_addr_b;
   assign m_all    = {m_busy, m_done, m_rd_en, m_rd_a, m_rd_b, m_z, m_bf_inv, m_layer,
                      m_wr_en, m_wr_a, m_wr_b};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp = 0;
   int   n_bad = 0;
   rd_t  q_rd[$];
   wr_t  q_wr[$];
   dir_t dirs[$];

   int   base, exp_done, cur_pl, busy_cnt, done_cnt, gap_cnt, gap_lo, gap_hi;
   logic active, dir_en, cur_inv, done_seen, had_issue;
   logic [7:0] last_a, last_b;
   logic [6:0] last_z;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      n_cmp++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cyc - base);
      end
   endtask

   // Reference order: textbook nested loops over layers, groups and butterflies.
   task automatic fill_model(input logic inv);
      int k;
      k = inv ? 127 : 1;
      for (int l = 0; l < 7; l++) begin
         int len;
         len = inv ? (2 << l) : (128 >> l);
         for (int s = 0; s < 256; s += 2 * len) begin
            for (int j = s; j < s + len; j++) begin
               rd_t e;
               e.a = 8'(j); e.b = 8'(j + len); e.z = 7'(k); e.layer = 3'(l); e.inv = inv;
               q_rd.push_back(e);
            end
            k = inv ? k - 1 : k + 1;
         end
      end
   endtask

   task automatic start_pass(input logic inv, input int exp, input logic directed);
      fill_model(inv);
      exp_done  = exp;
      dir_en    = directed;
      cur_pl    = sel ? 1 : 6;
      done_cnt  = 0;
      done_seen = 1'b0;
      busy_cnt  = 0;
      had_issue = 1'b0;
      gap_lo    = -1;
      gap_hi    = -2;
      @(posedge clk); #1;
      base    = cyc;
      cur_inv = inv;
      inverse = inv;
      start   = 1'b1;
      active  = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic wait_rel(input int n);
      while ((cyc - base) < n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic finish_pass();
      int t;
      t = 0;
      while (!done_seen && t < exp_done + 100) begin
         @(posedge clk);
         t++;
      end
      if (!done_seen) check("done_timeout", 64'(0), 64'(1));
      repeat (5) @(posedge clk);
      #1;
      check("done_pulses", 64'(done_cnt), 64'(1));
      check("rd_queue_empty", 64'(q_rd.size()), 64'(0));
      check("wr_queue_empty", 64'(q_wr.size()), 64'(0));
      active = 1'b0;
   endtask

   // Monitor: pops expected issues and write-backs whenever the DUT presents them.
   int   rel;
   rd_t  mon_e;
   logic exp_wr;
   always @(negedge clk) begin
      if (active && !reset) begin
         rel = cyc - base;
         if (m_busy) busy_cnt++;
         if (rel >= gap_lo && rel <= gap_hi && !m_rd_en) gap_cnt++;

         if (m_rd_en) begin
            if (q_rd.size() == 0) begin
               check("rd_unexpected", 64'(1), 64'(0));
            end else begin
               mon_e = q_rd.pop_front();
               check("rd_issue", 64'({m_rd_a, m_rd_b, m_z, m_layer, m_bf_inv}), 64'(mon_e));
               q_wr.push_back('{cyc + cur_pl, mon_e.a, mon_e.b});
               last_a = mon_e.a; last_b = mon_e.b; last_z = mon_e.z;
               had_issue = 1'b1;
            end
         end else if (had_issue) begin
            check("rd_hold_stable", 64'({m_rd_a, m_rd_b, m_z}), 64'({last_a, last_b, last_z}));
         end

         exp_wr = (q_wr.size() > 0) && (q_wr[0].cyc == cyc);
         if (exp_wr || m_wr_en) begin
            if (exp_wr) begin
               check("wr_back", 64'({m_wr_en, m_wr_a, m_wr_b}), 64'({1'b1, q_wr[0].a, q_wr[0].b}));
               void'(q_wr.pop_front());
            end else begin
               check("wr_unexpected", 64'(m_wr_en), 64'(0));
            end
         end

         if (dir_en) begin
            foreach (dirs[i]) begin
               if (dirs[i].inv == cur_inv && dirs[i].rel == rel) begin
                  if (dirs[i].wr)
                     check("dir_wr", 64'({m_wr_en, m_wr_a, m_wr_b}),
                           64'({1'b1, 8'(dirs[i].a), 8'(dirs[i].b)}));
                  else
                     check("dir_rd", 64'({m_rd_en, m_rd_a, m_rd_b, m_z}),
                           64'({1'b1, 8'(dirs[i].a), 8'(dirs[i].b), 7'(dirs[i].z)}));
               end
            end
         end

         if (m_done) begin
            done_cnt++;
            check("done_cycle", 64'(rel), 64'(exp_done));
            check("busy_at_done", 64'(m_busy), 64'(0));
            check("busy_cycles", 64'(busy_cnt), 64'(exp_done - 1));
            done_seen = 1'b1;
         end
      end
   end

   int wr_after;
   initial begin
      reset = 1'b1; start = 1'b0; inverse = 1'b0; hold = 1'b0; sel = 1'b0;
      active = 1'b0; dir_en = 1'b0; base = 0; gap_cnt = 0; gap_lo = -1; gap_hi = -2;
      // {inv, wr, rel, a, b, zeta}
      dirs.push_back('{1'b0, 1'b0,   1,   0, 128,   1});
      dirs.push_back('{1'b0, 1'b0,   2,   1, 129,   1});
      dirs.push_back('{1'b0, 1'b1,   7,   0, 128,   0});
      dirs.push_back('{1'b0, 1'b0, 135,   0,  64,   2});
      dirs.push_back('{1'b0, 1'b0, 199, 128, 192,   3});
      dirs.push_back('{1'b0, 1'b0, 805,   0,   2,  64});
      dirs.push_back('{1'b0, 1'b0, 806,   1,   3,  64});
      dirs.push_back('{1'b0, 1'b0, 807,   4,   6,  65});
      dirs.push_back('{1'b0, 1'b0, 932, 253, 255, 127});
      dirs.push_back('{1'b1, 1'b0,   1,   0,   2, 127});
      dirs.push_back('{1'b1, 1'b0,   2,   1,   3, 127});
      dirs.push_back('{1'b1, 1'b0,   3,   4,   6, 126});
      dirs.push_back('{1'b1, 1'b0, 805,   0, 128,   1});
      dirs.push_back('{1'b1, 1'b0, 932, 127, 255,   1});

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 64'(m_all), 64'(0));
      reset = 1'b0;

      start_pass(1'b0, 939, 1'b1);
      finish_pass();

      start_pass(1'b1, 939, 1'b1);
      finish_pass();

      // Hold during layer-0 drain (no effect) and 10 cycles mid-layer 2.
      start_pass(1'b0, 949, 1'b0);
      gap_cnt = 0; gap_lo = 269; gap_hi = 406;
      wait_rel(130); hold = 1'b1;
      wait_rel(133); hold = 1'b0;
      wait_rel(299); hold = 1'b1;
      wait_rel(309); hold = 1'b0;
      finish_pass();
      check("hold_gap_cycles", 64'(gap_cnt), 64'(10));

      // Reset mid-layer 3 with writes in flight, then a clean pass.
      start_pass(1'b0, 939, 1'b0);
      wait_rel(450);
      reset  = 1'b1;
      active = 1'b0;
      #1;
      check("reset_mid_pass", 64'(m_all), 64'(0));
      q_rd.delete();
      q_wr.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      wr_after = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_wr_en) wr_after++;
      end
      check("no_wr_after_reset", 64'(wr_after), 64'(0));
      start_pass(1'b0, 939, 1'b1);
      finish_pass();

      // PIPE_LAT=1 instance with a stray start while busy.
      sel = 1'b1;
      start_pass(1'b0, 904, 1'b0);
      wait_rel(300); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      finish_pass();

      repeat (50) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
